prio_encoder_stream: RTL and testbench

//   Parametrised N-to-log2(N) priority encoder with a registered output stage and a

---
 rtl/prio_encoder_stream.sv | 91 +++++++++
 tb/tb_prio_encoder_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_stream.sv
// Priority encoder with a one-deep registered output and valid/ready on both sides.
// MODE 0 picks the highest set index; MODE 1 round-robins from a rotating start pointer.
module prio_encoder_stream #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] w,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         any,
    output logic         multi
);

    logic         r_valid;
    logic [W-1:0] r_y;
    logic         r_any;
    logic         r_multi;
    logic [W-1:0] r_ptr;

    logic         w_accept;
    logic [W-1:0] w_idx;
    logic         w_any;
    logic         w_multi;
    logic         w_found;
    int           w_cnt;
    int           w_j;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_any    = |w;

    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        w_cnt   = 0;
        w_j     = 0;
        for (int i = 0; i < N; i++) begin
            if (w[i]) w_cnt = w_cnt + 1;
        end
        if (MODE == 1) begin
            // Ascend from the pointer, wrapping past N-1 back to 0.
            for (int k = 0; k < N; k++) begin
                w_j = int'(r_ptr) + k;
                if (w_j >= N) w_j = w_j - N;
                if (!w_found && w[w_j[W-1:0]]) begin
                    w_found = 1'b1;
                    w_idx   = w_j[W-1:0];
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w[i]) w_idx = W'(i);
            end
        end
        w_multi = (w_cnt >= 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_any   <= 1'b0;
            r_multi <= 1'b0;
            r_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_y     <= w_idx;
                r_any   <= w_any;
                r_multi <= w_multi;
                if (MODE == 1 && w_any) begin
                    r_ptr <= (w_idx == W'(N - 1)) ? '0 : w_idx + 1'b1;
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign y         = r_y;
    assign any       = r_any;
    assign multi     = r_multi;

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Bench for prio_encoder_stream: three instances (fixed N=8, round-robin N=8, round-robin N=5)
// exercised by directed tables/sequences and a randomized run against a behavioural model.
module tb_prio_encoder_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv[3];
    logic       ordy[3];
    logic [7:0] wv[3];
    logic       irdy[3];
    logic       ov[3];
    logic [2:0] yv[3];
    logic       anyv[3];
    logic       multv[3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prio_encoder_stream #(.N(8), .MODE(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .w(wv[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .y(yv[0]), .any(anyv[0]), .multi(multv[0]));

    prio_encoder_stream #(.N(8), .MODE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .w(wv[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .y(yv[1]), .any(anyv[1]), .multi(multv[1]));

    prio_encoder_stream #(.N(5), .MODE(1)) d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .w(wv[2][4:0]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .y(yv[2]), .any(anyv[2]), .multi(multv[2]));

    typedef struct {
        logic [7:0] w;
        int         y;
        int         any;
        int         multi;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Winner = set bit closest to the start position; fixed mode starts at the top and descends.
    function automatic int ref_y(input int mode, input int n, input int wd, input int ptr);
        int best  = 0;
        int bestd = n;
        int d;
        for (int i = 0; i < n; i++) begin
            if ((wd >> i) & 1) begin
                d = (mode == 1) ? (i - ptr + n) % n : (n - 1 - i);
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    int m_mode[3] = '{0, 1, 1};
    int m_n[3]    = '{8, 8, 5};
    int m_valid[3];
    int m_y[3];
    int m_any[3];
    int m_multi[3];
    int m_ptr[3];
    int m_acc[3];
    int wd;

    initial begin
        tbl[0]  = '{8'h01, 0, 1, 0};
        tbl[1]  = '{8'h02, 1, 1, 0};
        tbl[2]  = '{8'h04, 2, 1, 0};
        tbl[3]  = '{8'h08, 3, 1, 0};
        tbl[4]  = '{8'h10, 4, 1, 0};
        tbl[5]  = '{8'h20, 5, 1, 0};
        tbl[6]  = '{8'h40, 6, 1, 0};
        tbl[7]  = '{8'h80, 7, 1, 0};
        tbl[8]  = '{8'h00, 0, 0, 0};
        tbl[9]  = '{8'h52, 6, 1, 1};
        tbl[10] = '{8'h81, 7, 1, 1};
        tbl[11] = '{8'h3C, 5, 1, 1};

        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; wv[k] = 8'h00;
        end
        step();
        for (int k = 0; k < 3; k++) begin
            chk("reset_valid", int'(ov[k]), 0);
            chk("reset_y", int'(yv[k]), 0);
        end
        step();
        rst_n = 1'b1;

        // Fixed priority table
        for (int i = 0; i < 12; i++) begin
            iv[0] = 1'b1; wv[0] = tbl[i].w;
            step();
            chk("tbl_valid", int'(ov[0]), 1);
            chk("tbl_y", int'(yv[0]), tbl[i].y);
            chk("tbl_any", int'(anyv[0]), tbl[i].any);
            chk("tbl_multi", int'(multv[0]), tbl[i].multi);
        end
        iv[0] = 1'b0;
        step();
        chk("drain_valid", int'(ov[0]), 0);

        // Backpressure: result holds and input is refused while stalled
        iv[0] = 1'b1; wv[0] = 8'h10;
        step();
        chk("bp_y0", int'(yv[0]), 4);
        ordy[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wv[0] = 8'($urandom);
            #1;
            chk("bp_in_ready", int'(irdy[0]), 0);
            step();
            chk("bp_valid", int'(ov[0]), 1);
            chk("bp_y", int'(yv[0]), 4);
        end
        ordy[0] = 1'b1; wv[0] = 8'h03;
        #1;
        chk("bp_release_ready", int'(irdy[0]), 1);
        step();
        chk("bp_next_y", int'(yv[0]), 1);
        chk("bp_next_multi", int'(multv[0]), 1);
        iv[0] = 1'b0;
        step();

        // Round-robin sweep with all requests set
        iv[1] = 1'b1; wv[1] = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rr_sweep_y", int'(yv[1]), i % 8);
        end
        wv[1] = 8'h81;
        step();
        chk("rr_81_first", int'(yv[1]), 7);
        step();
        chk("rr_81_second", int'(yv[1]), 0);
        iv[1] = 1'b0;
        step();

        // Non-power-of-two wrap
        iv[2] = 1'b1; wv[2] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr5_y", int'(yv[2]), (i % 2 == 1) ? 4 : 0);
        end
        iv[2] = 1'b0;
        step();

        // Reset while a stalled result is held
        iv[1] = 1'b1; wv[1] = 8'hFF;
        step();
        chk("rst_pre_y", int'(yv[1]), 1);
        iv[1] = 1'b0; ordy[1] = 1'b0;
        step();
        chk("rst_hold_valid", int'(ov[1]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", int'(ov[1]), 0);
        chk("rst_async_y", int'(yv[1]), 0);
        chk("rst_async_any", int'(anyv[1]), 0);
        step();
        rst_n = 1'b1;
        ordy[1] = 1'b1; iv[1] = 1'b1; wv[1] = 8'hFF;
        step();
        chk("rst_after_valid", int'(ov[1]), 1);
        chk("rst_after_y", int'(yv[1]), 0);
        iv[1] = 1'b0;
        step();

        // Randomized run against the model
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0; m_y[k] = 0; m_any[k] = 0; m_multi[k] = 0; m_ptr[k] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 3) != 0);
                wv[k]   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                if (k == 2) wv[k] = wv[k] & 8'h1F;
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                chk("rnd_in_ready", int'(irdy[k]), int'(m_valid[k] == 0 || ordy[k]));
                m_acc[k] = int'(iv[k] && (m_valid[k] == 0 || ordy[k]));
            end
            step();
            for (int k = 0; k < 3; k++) begin
                wd = int'(wv[k]);
                if (m_acc[k] != 0) begin
                    m_valid[k] = 1;
                    m_y[k]     = ref_y(m_mode[k], m_n[k], wd, m_ptr[k]);
                    m_any[k]   = int'(wd != 0);
                    m_multi[k] = int'($countones(wv[k]) >= 2);
                    if (m_mode[k] == 1 && wd != 0) m_ptr[k] = (m_y[k] + 1) % m_n[k];
                end else if (ordy[k]) begin
                    m_valid[k] = 0;
                end
                chk("rnd_valid", int'(ov[k]), m_valid[k]);
                if (m_valid[k] != 0) begin
                    chk("rnd_y", int'(yv[k]), m_y[k]);
                    chk("rnd_any", int'(anyv[k]), m_any[k]);
                    chk("rnd_multi", int'(multv[k]), m_multi[k]);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
